// File: rtl/ctrl_core_gen2_if.sv
// ---------------------------------------------------------------------------
// ctrl_core_gen2_if
//
// Purpose
//   Bundles every handshake, status and result signal of the Sat Engine bin
//   sequencer (ctrl_core_gen2) into one interface, so the core, the stage
//   units and the bin scheduler share a single connection point.
//
// Parameters
//   WIDTH_LVL  width of decision level and bin number buses
//   WIDTH_CNT  width of the statistics counters
//
// Signals (direction seen from the core, i.e. the master modport)
//   start_core_i     in   start a bin (looked at in IDLE only)
//   abort_i          in   abandon the current bin
//   done_core_o      out  1-cycle pulse, verdict flags valid
//   start_imply_o    out  1-cycle pulse, run BCP
//   done_imply_i     in   BCP finished
//   conflict_i       in   BCP found a conflict (qualified by done_imply_i)
//   start_decision_o out  1-cycle pulse, make a decision
//   done_decision_i  in   decision finished
//   all_c_is_sat_i   in   all clauses satisfied (qualified by done_decision_i)
//   cur_lvl_i        in   current decision level (statistics only)
//   start_analyze_o  out  1-cycle pulse, conflict analysis
//   done_analyze_i   in   analysis finished
//   bkt_bin_num_i    in   bin targeted by backtrack (qualified by done_analyze_i)
//   cur_bin_num_i    in   bin currently loaded
//   start_bkt_o      out  1-cycle pulse, backtrack inside the current bin
//   done_bkt_i       in   backtrack finished
//   sat_o/unsat_o/undef_o/err_o  out  verdict flags, held until next start
//   state_o          out  current FSM state encoding
//   n_conflict_o, n_decision_o, max_lvl_o  out  only with CTRL_CORE_STATS_EN
//
// Optional feature macro: CTRL_CORE_STATS_EN
//
// Handshake semantics: each start_*_o is a single-cycle request issued in the
// first cycle of the matching stage state. The unit answers with a single
// done_*_i pulse, plus its qualifier, in any later cycle; a done that arrives
// in the same cycle as the request is not taken. The qualifier is only looked
// at in the cycle its done is high.
// ---------------------------------------------------------------------------
interface ctrl_core_gen2_if #(
    parameter int unsigned WIDTH_LVL = 16,
    parameter int unsigned WIDTH_CNT = 16
);
    logic                 start_core_i;
    logic                 abort_i;
    logic                 done_core_o;

    logic                 start_imply_o;
    logic                 done_imply_i;
    logic                 conflict_i;

    logic                 start_decision_o;
    logic                 done_decision_i;
    logic                 all_c_is_sat_i;
    logic [WIDTH_LVL-1:0] cur_lvl_i;

    logic                 start_analyze_o;
    logic                 done_analyze_i;
    logic [WIDTH_LVL-1:0] bkt_bin_num_i;
    logic [WIDTH_LVL-1:0] cur_bin_num_i;

    logic                 start_bkt_o;
    logic                 done_bkt_i;

    logic                 sat_o;
    logic                 unsat_o;
    logic                 undef_o;
    logic                 err_o;
    logic [3:0]           state_o;

`ifdef CTRL_CORE_STATS_EN
    logic [WIDTH_CNT-1:0] n_conflict_o;
    logic [WIDTH_CNT-1:0] n_decision_o;
    logic [WIDTH_LVL-1:0] max_lvl_o;
`endif

    // Core side.
    modport master (
`ifdef CTRL_CORE_STATS_EN
        output n_conflict_o, n_decision_o, max_lvl_o,
`endif
        input  start_core_i, abort_i,
        output done_core_o,
        output start_imply_o,
        input  done_imply_i, conflict_i,
        output start_decision_o,
        input  done_decision_i, all_c_is_sat_i, cur_lvl_i,
        output start_analyze_o,
        input  done_analyze_i, bkt_bin_num_i, cur_bin_num_i,
        output start_bkt_o,
        input  done_bkt_i,
        output sat_o, unsat_o, undef_o, err_o, state_o
    );

    // Stage units / scheduler side.
    modport slave (
`ifdef CTRL_CORE_STATS_EN
        input  n_conflict_o, n_decision_o, max_lvl_o,
`endif
        output start_core_i, abort_i,
        input  done_core_o,
        input  start_imply_o,
        output done_imply_i, conflict_i,
        input  start_decision_o,
        output done_decision_i, all_c_is_sat_i, cur_lvl_i,
        input  start_analyze_o,
        output done_analyze_i, bkt_bin_num_i, cur_bin_num_i,
        input  start_bkt_o,
        output done_bkt_i,
        input  sat_o, unsat_o, undef_o, err_o, state_o
    );
endinterface

// File: rtl/ctrl_core_gen2.sv
// ---------------------------------------------------------------------------
// ctrl_core_gen2
//
// Purpose
//   Sequencer for one loaded bin of the Sat Engine. Runs the loop
//   BCP -> DECISION -> ANALYSIS -> BKT_CUR_BIN, limits the number of
//   conflicts per bin, guards every stage with a watchdog, honours abort and
//   reports a verdict (sat / unsat / undef / err) to the bin scheduler.
//
// Parameters
//   WIDTH_LVL     width of decision level and bin number buses
//   WIDTH_CNT     width of conflict counter and watchdog counter
//   MAX_CONFLICT  conflicts allowed per bin before undef; 0 = unlimited
//   WDOG_CYC      cycles a stage may wait for its done before err;
//                 0 = watchdog disabled
//
// Ports
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   ctrl_core_gen2_if.master: stage handshakes, verdict flags,
//         state_o debug view and (optionally) statistics
//
// Optional feature macro: CTRL_CORE_STATS_EN adds n_conflict_o,
// n_decision_o and max_lvl_o to the interface and the registers behind them.
//
// State encoding on state_o:
//   IDLE=0 BCP=1 DECISION=2 ANALYSIS=3 BKT_CUR_BIN=4
//   PARTIAL_SAT=5 PARTIAL_UNSAT=6 PARTIAL_UNDEF=7 ERROR=8
// ---------------------------------------------------------------------------
module ctrl_core_gen2 #(
    parameter int unsigned WIDTH_LVL    = 16,
    parameter int unsigned WIDTH_CNT    = 16,
    parameter int unsigned MAX_CONFLICT = 1024,
    parameter int unsigned WDOG_CYC     = 4096
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_core_gen2_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_BCP      = 4'd1,
        S_DECISION = 4'd2,
        S_ANALYSIS = 4'd3,
        S_BKT      = 4'd4,
        S_PSAT     = 4'd5,
        S_PUNSAT   = 4'd6,
        S_PUNDEF   = 4'd7,
        S_ERROR    = 4'd8
    } state_t;

    localparam logic [WIDTH_CNT-1:0] CNT_ALL_ONES = '1;
    localparam bit                   WDOG_EN      = (WDOG_CYC != 0);
    localparam bit                   BUDGET_EN    = (MAX_CONFLICT != 0);
    // Last count value a stage may sit at; only meaningful when WDOG_EN.
    localparam logic [WIDTH_CNT-1:0] WDOG_LAST    =
        WDOG_EN ? WIDTH_CNT'(WDOG_CYC - 1) : '0;

    state_t               state;
    state_t               state_next;
    logic                 first_q;       // high in the first cycle of a state
    logic [WIDTH_CNT-1:0] conflict_cnt;
    logic [WIDTH_CNT-1:0] wdog_cnt;
    logic                 sat_q;
    logic                 unsat_q;
    logic                 undef_q;
    logic                 err_q;

    logic                 start_accept;
    logic                 is_stage;
    logic                 wdog_hit;
    logic                 budget_spent;
    logic                 conflict_inc;
    logic                 decision_acc;

    assign start_accept = (state == S_IDLE) && bus.start_core_i;

    assign is_stage = (state == S_BCP) || (state == S_DECISION) ||
                      (state == S_ANALYSIS) || (state == S_BKT);

    assign wdog_hit = WDOG_EN && (wdog_cnt == WDOG_LAST);

    // The counter already includes the conflict that led into ANALYSIS.
    assign budget_spent = BUDGET_EN && (32'(conflict_cnt) >= MAX_CONFLICT);

    // ------------------------------------------------------------------
    // Next-state logic. Abort beats the watchdog, which beats any done.
    // Dones are not taken in the first cycle of a stage (the request cycle).
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        conflict_inc = 1'b0;
        decision_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_core_i) begin
                    state_next = S_BCP;
                end
            end
            S_BCP: begin
                if (bus.abort_i) begin
                    state_next = S_PUNDEF;
                end else if (wdog_hit) begin
                    state_next = S_ERROR;
                end else if (!first_q && bus.done_imply_i) begin
                    if (bus.conflict_i) begin
                        state_next   = S_ANALYSIS;
                        conflict_inc = 1'b1;
                    end else begin
                        state_next = S_DECISION;
                    end
                end
            end
            S_DECISION: begin
                if (bus.abort_i) begin
                    state_next = S_PUNDEF;
                end else if (wdog_hit) begin
                    state_next = S_ERROR;
                end else if (!first_q && bus.done_decision_i) begin
                    decision_acc = 1'b1;
                    state_next   = bus.all_c_is_sat_i ? S_PSAT : S_BCP;
                end
            end
            S_ANALYSIS: begin
                if (bus.abort_i) begin
                    state_next = S_PUNDEF;
                end else if (wdog_hit) begin
                    state_next = S_ERROR;
                end else if (!first_q && bus.done_analyze_i) begin
                    if (bus.bkt_bin_num_i != bus.cur_bin_num_i) begin
                        state_next = S_PUNSAT;
                    end else if (budget_spent) begin
                        state_next = S_PUNDEF;
                    end else begin
                        state_next = S_BKT;
                    end
                end
            end
            S_BKT: begin
                if (bus.abort_i) begin
                    state_next = S_PUNDEF;
                end else if (wdog_hit) begin
                    state_next = S_ERROR;
                end else if (!first_q && bus.done_bkt_i) begin
                    state_next = S_DECISION;
                end
            end
            // Verdict states last one cycle; unused encodings also recover.
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and first-cycle marker. No state loops onto itself
    // through a transition, so a change of state is always a fresh entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            first_q <= 1'b0;
        end else begin
            state   <= state_next;
            first_q <= (state_next != state);
        end
    end

    // Watchdog: counts cycles spent in a stage, restarts on every change.
    // It saturates so a disabled watchdog never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= '0;
        end else if (state_next != state) begin
            wdog_cnt <= '0;
        end else if (is_stage && (wdog_cnt != CNT_ALL_ONES)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // Conflict counter: cleared by an accepted start, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (start_accept) begin
            conflict_cnt <= '0;
        end else if (conflict_inc && (conflict_cnt != CNT_ALL_ONES)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // Verdict flags: raised on entry to a verdict state, so they are already
    // valid in the done_core_o cycle, and held until the next bin starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q   <= 1'b0;
            unsat_q <= 1'b0;
            undef_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (start_accept) begin
            sat_q   <= 1'b0;
            unsat_q <= 1'b0;
            undef_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_next == S_PSAT)   sat_q   <= 1'b1;
            if (state_next == S_PUNSAT) unsat_q <= 1'b1;
            if (state_next == S_PUNDEF) undef_q <= 1'b1;
            if (state_next == S_ERROR)  err_q   <= 1'b1;
        end
    end

    // Outputs are decoded from registers only, so none of them depends
    // combinationally on an input.
    assign bus.start_imply_o    = (state == S_BCP)      && first_q;
    assign bus.start_decision_o = (state == S_DECISION) && first_q;
    assign bus.start_analyze_o  = (state == S_ANALYSIS) && first_q;
    assign bus.start_bkt_o      = (state == S_BKT)      && first_q;

    assign bus.done_core_o = (state == S_PSAT) || (state == S_PUNSAT) ||
                             (state == S_PUNDEF) || (state == S_ERROR);

    assign bus.sat_o   = sat_q;
    assign bus.unsat_o = unsat_q;
    assign bus.undef_o = undef_q;
    assign bus.err_o   = err_q;
    assign bus.state_o = state;

`ifdef CTRL_CORE_STATS_EN
    logic [WIDTH_CNT-1:0] n_decision_q;
    logic [WIDTH_LVL-1:0] max_lvl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_decision_q <= '0;
            max_lvl_q    <= '0;
        end else if (start_accept) begin
            n_decision_q <= '0;
            max_lvl_q    <= '0;
        end else begin
            if (decision_acc && (n_decision_q != CNT_ALL_ONES)) begin
                n_decision_q <= n_decision_q + 1'b1;
            end
            if ((state != S_IDLE) && (bus.cur_lvl_i > max_lvl_q)) begin
                max_lvl_q <= bus.cur_lvl_i;
            end
        end
    end

    assign bus.n_conflict_o = conflict_cnt;
    assign bus.n_decision_o = n_decision_q;
    assign bus.max_lvl_o    = max_lvl_q;
`else
    // Without statistics the level bus and the decision strobe feed nothing.
    logic unused_stats;
    assign unused_stats = ^{bus.cur_lvl_i, decision_acc};
`endif

endmodule

// File: tb/tb_ctrl_core_gen2.sv
// ---------------------------------------------------------------------------
// tb_ctrl_core_gen2
//
// Bench for ctrl_core_gen2 (MAX_CONFLICT=2, WDOG_CYC=16). A bin is described
// as a script of stage responses; the reference model walks the stage rules
// to build the script and the bin verdict together. The driver plays the
// script against the core, the monitor pops verdicts whenever done_core_o
// fires.
// ---------------------------------------------------------------------------
module tb_ctrl_core_gen2;

    localparam int WL   = 16;
    localparam int WC   = 16;
    localparam int MAXC = 2;
    localparam int WDOG = 16;

    // verdict packing: {err, undef, unsat, sat}
    localparam logic [3:0] V_SAT   = 4'b0001;
    localparam logic [3:0] V_UNSAT = 4'b0010;
    localparam logic [3:0] V_UNDEF = 4'b0100;
    localparam logic [3:0] V_ERR   = 4'b1000;

    localparam int K_BCP = 1;
    localparam int K_DEC = 2;
    localparam int K_ANA = 3;
    localparam int K_BKT = 4;

    typedef struct {
        int          kind;
        int          delay;
        bit          flag;     // conflict / all sat / foreign bin
        bit          decoy;    // done in the request cycle with inverted flag
        bit          abort_s;
        bit          stall;
        logic [15:0] bkt;      // foreign bin number for ANALYSIS
    } step_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_core_gen2_if #(.WIDTH_LVL(WL), .WIDTH_CNT(WC)) bus();

    ctrl_core_gen2 #(
        .WIDTH_LVL(WL), .WIDTH_CNT(WC), .MAX_CONFLICT(MAXC), .WDOG_CYC(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [3:0]  exp_q[$];
    step_t       script_q[$];
    logic [15:0] cur_bin;
    int          bkt_seen = 0;
    bit          prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outvec();
        return {19'b0, bus.done_core_o, bus.start_imply_o, bus.start_decision_o,
                bus.start_analyze_o, bus.start_bkt_o, bus.sat_o, bus.unsat_o,
                bus.undef_o, bus.err_o, bus.state_o};
    endfunction

    function automatic logic [3:0] term_code(input logic [3:0] v);
        case (v)
            V_SAT:   return 4'd5;
            V_UNSAT: return 4'd6;
            V_UNDEF: return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.start_bkt_o) bkt_seen++;
            if (prev_done) begin
                check("done_core_width_and_idle", {27'b0, bus.done_core_o, bus.state_o}, 32'd0);
            end
            if (bus.done_core_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done_core: got verdict 0x%0h expected none at %0t",
                             {bus.err_o, bus.undef_o, bus.unsat_o, bus.sat_o}, $time);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("verdict", {28'b0, bus.err_o, bus.undef_o, bus.unsat_o, bus.sat_o}, {28'b0, e});
                    check("verdict_state", {28'b0, bus.state_o}, {28'b0, term_code(e)});
                end
            end
            prev_done = bus.done_core_o;
        end
    end

    // ---------------- reference model ----------------
    function automatic step_t mk(input int kind, input bit flag);
        step_t s;
        s.kind    = kind;
        s.flag    = flag;
        s.delay   = $urandom_range(1, 6);
        s.decoy   = ($urandom_range(0, 3) == 0);
        s.abort_s = 1'b0;
        s.stall   = 1'b0;
        s.bkt     = cur_bin + 16'($urandom_range(1, 50));
        return s;
    endfunction

    // Walks the stage rules with random unit answers; returns the verdict.
    function automatic logic [3:0] gen_bin();
        int         conflicts = 0;
        int         stage = K_BCP;
        int         steps = 0;
        logic [3:0] v = 4'b0;
        step_t      s;
        bit         f;
        script_q.delete();
        while (v == 4'b0) begin
            steps++;
            if ($urandom_range(0, 29) == 0) begin
                s = mk(stage, 1'($urandom_range(0, 1)));
                s.abort_s = 1'b1;
                script_q.push_back(s);
                v = V_UNDEF;
            end else if ($urandom_range(0, 39) == 0) begin
                s = mk(stage, 1'b0);
                s.stall = 1'b1;
                script_q.push_back(s);
                v = V_ERR;
            end else begin
                case (stage)
                    K_BCP: begin
                        f = ($urandom_range(0, 2) == 0);
                        script_q.push_back(mk(K_BCP, f));
                        if (f) begin
                            conflicts++;
                            stage = K_ANA;
                        end else begin
                            stage = K_DEC;
                        end
                    end
                    K_DEC: begin
                        f = (steps > 30) || ($urandom_range(0, 3) == 0);
                        script_q.push_back(mk(K_DEC, f));
                        if (f) v = V_SAT;
                        else   stage = K_BCP;
                    end
                    K_ANA: begin
                        f = ($urandom_range(0, 3) == 0);
                        script_q.push_back(mk(K_ANA, f));
                        if (f)                      v = V_UNSAT;
                        else if (conflicts >= MAXC) v = V_UNDEF;
                        else                        stage = K_BKT;
                    end
                    default: begin
                        script_q.push_back(mk(K_BKT, 1'b0));
                        stage = K_DEC;
                    end
                endcase
            end
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic clear_inputs();
        bus.start_core_i    = 1'b0;
        bus.abort_i         = 1'b0;
        bus.done_imply_i    = 1'b0;
        bus.conflict_i      = 1'b0;
        bus.done_decision_i = 1'b0;
        bus.all_c_is_sat_i  = 1'b0;
        bus.done_analyze_i  = 1'b0;
        bus.done_bkt_i      = 1'b0;
    endtask

    task automatic drive_done(input step_t s, input bit invert);
        bit f;
        f = s.flag ^ invert;
        case (s.kind)
            K_BCP: begin bus.done_imply_i = 1'b1; bus.conflict_i = f; end
            K_DEC: begin bus.done_decision_i = 1'b1; bus.all_c_is_sat_i = f; end
            K_ANA: begin
                bus.done_analyze_i = 1'b1;
                bus.bkt_bin_num_i  = f ? s.bkt : cur_bin;
            end
            default: bus.done_bkt_i = 1'b1;
        endcase
    endtask

    task automatic wait_pulse(output int kind);
        logic [3:0] pv;
        kind = 0;
        for (int c = 0; c < 8 && kind == 0; c++) begin
            @(negedge clk);
            clear_inputs();
            pv = {bus.start_bkt_o, bus.start_analyze_o, bus.start_decision_o, bus.start_imply_o};
            case (pv)
                4'b0001: kind = K_BCP;
                4'b0010: kind = K_DEC;
                4'b0100: kind = K_ANA;
                4'b1000: kind = K_BKT;
                4'b0000: kind = 0;
                default: kind = -1;
            endcase
        end
    endtask

    task automatic run_bin(input logic [3:0] exp, input bit push_exp,
                           input bit poke_start, input bit reset_in_ana);
        int    kind;
        int    cnt;
        step_t s;
        if (push_exp) exp_q.push_back(exp);
        bus.cur_bin_num_i = cur_bin;
        bus.start_core_i  = 1'b1;
        for (int i = 0; i < script_q.size(); i++) begin
            s = script_q[i];
            wait_pulse(kind);
            check("stage_pulse", kind, s.kind);
            if (kind != s.kind) begin
                repeat (40) @(negedge clk);
                clear_inputs();
                return;
            end
            if (reset_in_ana && kind == K_ANA) begin
                #1 rst = 1'b0;
                #1 check("async_reset_outputs", outvec(), 32'd0);
                @(negedge clk);
                rst = 1'b1;
                clear_inputs();
                return;
            end
            if (s.decoy) drive_done(s, 1'b1);
            if (s.stall) begin
                cnt = 0;
                for (int c = 1; c <= 40 && cnt == 0; c++) begin
                    @(negedge clk);
                    clear_inputs();
                    if (bus.done_core_o) cnt = c;
                end
                check("wdog_latency", cnt, WDOG);
                @(negedge clk);
                return;
            end
            for (int d = 0; d < s.delay; d++) begin
                @(negedge clk);
                clear_inputs();
                if (d == 0) check("stage_pulse_width", outvec() & 32'h0F00, 32'd0);
                if (poke_start && s.kind == K_BCP && d == 0) bus.start_core_i = 1'b1;
            end
            drive_done(s, 1'b0);
            if (s.abort_s) bus.abort_i = 1'b1;
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        step_t      s;
        logic [3:0] v;
        clear_inputs();
        bus.cur_lvl_i     = '0;
        bus.cur_bin_num_i = '0;
        bus.bkt_bin_num_i = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outvec(), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outvec(), 32'd0);

        // abort while idle does nothing
        bus.abort_i = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("abort_in_idle", outvec(), 32'd0);

        // T1: plain sat
        cur_bin = 16'd7;
        script_q.delete();
        script_q.push_back(mk(K_BCP, 1'b0));
        script_q.push_back(mk(K_DEC, 1'b1));
        run_bin(V_SAT, 1'b1, 1'b0, 1'b0);

        // T2: backtrack to another bin, no backtrack request
        cur_bin  = 16'd5;
        bkt_seen = 0;
        script_q.delete();
        script_q.push_back(mk(K_BCP, 1'b1));
        s = mk(K_ANA, 1'b1);
        s.bkt = 16'd3;
        script_q.push_back(s);
        run_bin(V_UNSAT, 1'b1, 1'b0, 1'b0);
        check("t2_no_bkt_pulse", bkt_seen, 0);

        // T3: budget of two conflicts
        cur_bin = 16'd9;
        bus.cur_lvl_i = 16'd7;
        script_q.delete();
        script_q.push_back(mk(K_BCP, 1'b1));
        script_q.push_back(mk(K_ANA, 1'b0));
        script_q.push_back(mk(K_BKT, 1'b0));
        script_q.push_back(mk(K_DEC, 1'b0));
        script_q.push_back(mk(K_BCP, 1'b1));
        script_q.push_back(mk(K_ANA, 1'b0));
        run_bin(V_UNDEF, 1'b1, 1'b0, 1'b0);
`ifdef CTRL_CORE_STATS_EN
        check("t3_n_conflict", bus.n_conflict_o, 32'd2);
        check("t3_n_decision", bus.n_decision_o, 32'd1);
        check("t3_max_lvl", bus.max_lvl_o, 32'd7);
`endif
        bus.cur_lvl_i = '0;

        // T4: withheld done -> watchdog
        script_q.delete();
        s = mk(K_BCP, 1'b0);
        s.stall = 1'b1;
        script_q.push_back(s);
        run_bin(V_ERR, 1'b1, 1'b0, 1'b0);

        // T5: abort with done_decision, start during BCP ignored
        script_q.delete();
        s = mk(K_BCP, 1'b0);
        s.delay = 3;
        script_q.push_back(s);
        s = mk(K_DEC, 1'b1);
        s.abort_s = 1'b1;
        s.decoy   = 1'b0;
        script_q.push_back(s);
        run_bin(V_UNDEF, 1'b1, 1'b1, 1'b0);

        // T6: reset in ANALYSIS, then a fresh bin
        script_q.delete();
        script_q.push_back(mk(K_BCP, 1'b1));
        script_q.push_back(mk(K_ANA, 1'b0));
        run_bin(4'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("idle_after_midrun_reset", outvec(), 32'd0);
        script_q.delete();
        script_q.push_back(mk(K_BCP, 1'b0));
        script_q.push_back(mk(K_DEC, 1'b1));
        run_bin(V_SAT, 1'b1, 1'b0, 1'b0);

        // random bins
        repeat (60) begin
            cur_bin = 16'($urandom);
            v = gen_bin();
            run_bin(v, 1'b1, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
